// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - control/address bundle between the FFT sequencer and the butterfly datapath
interface fft_stage_sequencer_if #(
    parameter int N_LOG2 = 3
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        stage;
    logic              bf_valid;
    logic [N_LOG2-1:0] rd_addr_a;
    logic [N_LOG2-1:0] rd_addr_b;
    logic [N_LOG2-2:0] tw_idx;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_a;
    logic [N_LOG2-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage, bf_valid, rd_addr_a, rd_addr_b, tw_idx,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage, bf_valid, rd_addr_a, rd_addr_b, tw_idx,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage/butterfly sequencer for an in-place radix-2 DIT FFT
module fft_stage_sequencer #(
    parameter int N_LOG2 = 3,
    parameter int BF_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.master bus
);
    localparam int         KW     = N_LOG2 - 1;
    localparam int         PW     = 2 * N_LOG2 + 1;
    localparam logic [3:0] LAST_S = 4'(N_LOG2 - 1);
    localparam logic [3:0] LAST_D = 4'(BF_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [3:0]        s_q;
    logic [3:0]        d_q;
    logic [KW-1:0]     k_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [N_LOG2-1:0] a_q;
    logic [N_LOG2-1:0] b_q;
    logic [KW-1:0]     tw_q;
    logic [PW-1:0]     pipe [BF_LAT];

    logic              do_issue;
    logic [3:0]        nxt_s;
    logic [KW-1:0]     nxt_k;
    logic [N_LOG2-1:0] nxt_kx;
    logic [N_LOG2-1:0] mask;
    logic [N_LOG2-1:0] nxt_p;
    logic [N_LOG2-1:0] nxt_a;
    logic [N_LOG2-1:0] nxt_b;
    logic [KW-1:0]     nxt_tw;

    // Coordinates of the butterfly issued next cycle, and its addresses.
    // Clearing the low s bits of k and shifting left inserts the zero at bit s
    // that separates the upper leg a from its partner b = a + 2^s.
    always_comb begin
        do_issue = 1'b0;
        nxt_s    = s_q;
        nxt_k    = KW'(k_q + 1'b1);
        case (state)
            IDLE: begin
                do_issue = bus.start;
                nxt_s    = '0;
                nxt_k    = '0;
            end
            RUN: do_issue = ~(&k_q);
            DRAIN: begin
                do_issue = (d_q == LAST_D) && (s_q != LAST_S);
                nxt_s    = 4'(s_q + 4'd1);
                nxt_k    = '0;
            end
            default: do_issue = 1'b0;
        endcase
        nxt_kx = {1'b0, nxt_k};
        mask   = ~({N_LOG2{1'b1}} << nxt_s);
        nxt_p  = nxt_kx & mask;
        nxt_a  = ((nxt_kx & ~mask) << 1) | nxt_p;
        nxt_b  = nxt_a | (N_LOG2'(1) << nxt_s);
        nxt_tw = KW'(nxt_p << (LAST_S - nxt_s));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            // The write-back line shifts unconditionally so drains complete in-flight writes.
            pipe[0] <= {valid_q, a_q, b_q};
            for (int i = 1; i < BF_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            valid_q <= do_issue;
            a_q     <= do_issue ? nxt_a : '0;
            b_q     <= do_issue ? nxt_b : '0;
            tw_q    <= do_issue ? nxt_tw : '0;
            done_q  <= 1'b0;
            if (do_issue) begin
                s_q <= nxt_s;
                k_q <= nxt_k;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (&k_q) begin
                        state <= DRAIN;
                        d_q   <= '0;
                    end
                end
                DRAIN: begin
                    if (d_q == LAST_D) begin
                        if (s_q == LAST_S) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        d_q <= 4'(d_q + 4'd1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = s_q;
    assign bus.bf_valid  = valid_q;
    assign bus.rd_addr_a = a_q;
    assign bus.rd_addr_b = b_q;
    assign bus.tw_idx    = tw_q;
    assign bus.wr_en     = pipe[BF_LAT-1][PW-1];
    assign bus.wr_addr_a = pipe[BF_LAT-1][2*N_LOG2-1:N_LOG2];
    assign bus.wr_addr_b = pipe[BF_LAT-1][N_LOG2-1:0];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - scoreboard bench for fft_stage_sequencer in two configurations
module tb_fft_stage_sequencer;
    typedef struct {
        int cyc;
        int s;
        int a;
        int b;
        int tw;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_sig [2];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic end_req = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int cfg, input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s cycle=%0d actual=%0d required=%0d", cfg, name, cyc, act, exp);
        end
    endtask

    // cfg 0: N=8, BF_LAT=3 ; cfg 1: N=16, BF_LAT=1
    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int NL = (g == 0) ? 3 : 4;
        localparam int BL = (g == 0) ? 3 : 1;
        localparam int H  = 1 << (NL - 1);
        localparam int L  = NL * (H + BL);

        fft_stage_sequencer_if #(.N_LOG2(NL)) ifc ();
        fft_stage_sequencer #(.N_LOG2(NL), .BF_LAT(BL)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
        assign ifc.start = start_sig[g];

        ev_t iq[$];
        ev_t wq[$];
        int  bs        = -1;
        int  be        = -1;
        int  de        = -1;
        int  next_idle = 0;
        bit  after_rst = 1'b0;

        // Reference model: on an accepted start, enumerate every butterfly of the transform.
        always @(posedge clk) begin
            int cur;
            cur       = cyc;
            after_rst = rst;
            if (rst) begin
                iq.delete();
                wq.delete();
                bs        = -1;
                be        = -1;
                de        = -1;
                next_idle = cur + 1;
            end else if (start_sig[g] && cur >= next_idle) begin
                for (int s = 0; s < NL; s++) begin
                    for (int k = 0; k < H; k++) begin
                        ev_t e;
                        int  half;
                        int  j;
                        int  p;
                        half  = 1 << s;
                        j     = k / half;
                        p     = k % half;
                        e.cyc = cur + 1 + s * (H + BL) + k;
                        e.s   = s;
                        e.a   = j * 2 * half + p;
                        e.b   = e.a + half;
                        e.tw  = p * (1 << (NL - 1 - s));
                        iq.push_back(e);
                        e.cyc = e.cyc + BL;
                        wq.push_back(e);
                    end
                end
                bs        = cur + 1;
                be        = cur + L;
                de        = cur + L + 1;
                next_idle = cur + L + 2;
            end
        end

        always @(negedge clk) begin
            if (after_rst) begin
                chk(g, "rst_stage", int'(ifc.stage), 0);
                chk(g, "rst_rd_a", int'(ifc.rd_addr_a), 0);
                chk(g, "rst_rd_b", int'(ifc.rd_addr_b), 0);
                chk(g, "rst_tw", int'(ifc.tw_idx), 0);
                chk(g, "rst_wr_a", int'(ifc.wr_addr_a), 0);
                chk(g, "rst_wr_b", int'(ifc.wr_addr_b), 0);
            end
            chk(g, "busy", int'(ifc.busy), int'(cyc >= bs && cyc <= be));
            chk(g, "done", int'(ifc.done), int'(cyc == de));

            while (iq.size() > 0 && iq[0].cyc < cyc) begin
                chk(g, "issue_missing_at", cyc, iq[0].cyc);
                void'(iq.pop_front());
            end
            if (ifc.bf_valid !== 1'b0) begin
                if (iq.size() == 0) begin
                    chk(g, "issue_unexpected", int'(ifc.bf_valid), 0);
                end else begin
                    ev_t e;
                    e = iq.pop_front();
                    chk(g, "issue_cycle", cyc, e.cyc);
                    chk(g, "issue_stage", int'(ifc.stage), e.s);
                    chk(g, "rd_addr_a", int'(ifc.rd_addr_a), e.a);
                    chk(g, "rd_addr_b", int'(ifc.rd_addr_b), e.b);
                    chk(g, "tw_idx", int'(ifc.tw_idx), e.tw);
                end
            end

            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk(g, "write_missing_at", cyc, wq[0].cyc);
                void'(wq.pop_front());
            end
            if (ifc.wr_en !== 1'b0) begin
                if (wq.size() == 0) begin
                    chk(g, "write_unexpected", int'(ifc.wr_en), 0);
                end else begin
                    ev_t e;
                    e = wq.pop_front();
                    chk(g, "write_cycle", cyc, e.cyc);
                    chk(g, "wr_addr_a", int'(ifc.wr_addr_a), e.a);
                    chk(g, "wr_addr_b", int'(ifc.wr_addr_b), e.b);
                end
            end
        end

        initial begin
            wait (end_req);
            chk(g, "issues_left", iq.size(), 0);
            chk(g, "writes_left", wq.size(), 0);
        end
    end

    initial begin
        start_sig[0] = 1'b0;
        start_sig[1] = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // One transform, with a stray start pulse while busy.
        @(negedge clk) start_sig[0] = 1'b1;
        @(negedge clk) start_sig[0] = 1'b0;
        repeat (4) @(negedge clk);
        start_sig[0] = 1'b1;
        @(negedge clk) start_sig[0] = 1'b0;
        repeat (30) @(negedge clk);

        // Reset lands on the second issue of stage 1 (9 cycles after the start edge).
        start_sig[0] = 1'b1;
        @(negedge clk) start_sig[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        start_sig[0] = 1'b1;
        @(negedge clk) start_sig[0] = 1'b0;
        repeat (30) @(negedge clk);

        // Reset and start together: reset must win.
        rst          = 1'b1;
        start_sig[0] = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        start_sig[0] = 1'b0;
        repeat (5) @(negedge clk);

        // Start held high on the large configuration: back-to-back transforms.
        start_sig[1] = 1'b1;
        repeat (130) @(negedge clk);
        start_sig[1] = 1'b0;
        repeat (50) @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            start_sig[0] = ($urandom_range(0, 5) == 0);
            start_sig[1] = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        start_sig[0] = 1'b0;
        start_sig[1] = 1'b0;
        rst          = 1'b0;
        repeat (60) @(negedge clk);

        end_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
